parking_lot_ctrl: RTL and testbench

//  Parametrised parking-lot controller: tracks NUM_SLOTS spots and allocates the lowest free spot on entry.

---
 rtl/parking_lot_if.sv | 30 +++
 rtl/parking_lot_ctrl.sv | 108 ++++++++++
 tb/tb_parking_lot_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_lot_if.sv
// parking_lot_if: sensor/actuator bundle between the lot front-end and parking_lot_ctrl.
interface parking_lot_if #(
   parameter int NUM_SLOTS = 8,
   parameter int SLOT_W    = $clog2(NUM_SLOTS),
   parameter int CNT_W     = $clog2(NUM_SLOTS + 1)
);
   logic                 entry_req;
   logic                 exit_req;
   logic [SLOT_W-1:0]    exit_slot;
   logic                 entry_ack;
   logic [SLOT_W-1:0]    entry_slot;
   logic                 entry_reject;
   logic                 exit_ack;
   logic                 exit_err;
   logic                 gate_open;
   logic [NUM_SLOTS-1:0] occupied;
   logic [CNT_W-1:0]     free_count;
   logic                 is_full;
   logic                 is_empty;
   modport master (
      output entry_req, exit_req, exit_slot,
      input  entry_ack, entry_slot, entry_reject, exit_ack, exit_err,
             gate_open, occupied, free_count, is_full, is_empty
   );
   modport slave (
      input  entry_req, exit_req, exit_slot,
      output entry_ack, entry_slot, entry_reject, exit_ack, exit_err,
             gate_open, occupied, free_count, is_full, is_empty
   );
endinterface

// File: rtl/parking_lot_ctrl.sv
// parking_lot_ctrl: lowest-free-spot allocator with exit checking, occupancy flags
// and a retriggerable timed barrier gate; all outputs registered, latency 1.
module parking_lot_ctrl #(
   parameter int NUM_SLOTS        = 8,
   parameter int SLOT_W           = $clog2(NUM_SLOTS),
   parameter int CNT_W            = $clog2(NUM_SLOTS + 1),
   parameter int GATE_OPEN_CYCLES = 4
) (
   input  logic          clk,
   input  logic          reset,
   parking_lot_if.slave  bus
);
   localparam int TW  = $clog2(GATE_OPEN_CYCLES + 1);
   localparam int PAD = 1 << SLOT_W;
   typedef enum logic {IDLE, OPEN} gate_e;
   gate_e                state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [NUM_SLOTS-1:0] occ_q, occ_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [SLOT_W-1:0]    entry_slot_q, entry_slot_d;
   logic                 entry_ack_q, entry_ack_d;
   logic                 entry_reject_q, entry_reject_d;
   logic                 exit_ack_q, exit_ack_d;
   logic                 exit_err_q, exit_err_d;
   logic                 full_q, full_d;
   logic                 empty_q, empty_d;
   logic [SLOT_W-1:0]    free_idx;
   logic                 any_free;
   logic [PAD-1:0]       occ_pad;
   logic                 entry_ok, exit_ok, event_ok;
   // Descending scan so the lowest free index is the one left standing.
   always_comb begin
      free_idx = '0;
      any_free = 1'b0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--)
         if (!occ_q[i]) begin
            free_idx = SLOT_W'(i);
            any_free = 1'b1;
         end
   end
   // Both requests see the pre-edge map, so a spot freed now cannot be re-issued now.
   always_comb begin
      occ_pad        = PAD'(occ_q);
      entry_ok       = bus.entry_req && any_free;
      exit_ok        = bus.exit_req && (int'(bus.exit_slot) < NUM_SLOTS) && occ_pad[bus.exit_slot];
      event_ok       = entry_ok || exit_ok;
      occ_d          = (occ_q | (entry_ok ? NUM_SLOTS'(1) << free_idx : '0))
                       & ~(exit_ok ? NUM_SLOTS'(1) << bus.exit_slot : '0);
      cnt_d          = cnt_q + CNT_W'(exit_ok) - CNT_W'(entry_ok);
      full_d         = cnt_d == '0;
      empty_d        = cnt_d == CNT_W'(NUM_SLOTS);
      entry_slot_d   = entry_ok ? free_idx : entry_slot_q;
      entry_ack_d    = entry_ok;
      entry_reject_d = bus.entry_req && !any_free;
      exit_ack_d     = exit_ok;
      exit_err_d     = bus.exit_req && !exit_ok;
   end
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      if (event_ok) begin
         state_d = OPEN;
         timer_d = TW'(GATE_OPEN_CYCLES);
      end else if (state_q == OPEN) begin
         state_d = timer_q > TW'(1) ? OPEN : IDLE;
         timer_d = timer_q > TW'(1) ? timer_q - TW'(1) : '0;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         timer_q        <= '0;
         occ_q          <= '0;
         cnt_q          <= CNT_W'(NUM_SLOTS);
         full_q         <= 1'b0;
         empty_q        <= 1'b1;
         entry_slot_q   <= '0;
         entry_ack_q    <= 1'b0;
         entry_reject_q <= 1'b0;
         exit_ack_q     <= 1'b0;
         exit_err_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         occ_q          <= occ_d;
         cnt_q          <= cnt_d;
         full_q         <= full_d;
         empty_q        <= empty_d;
         entry_slot_q   <= entry_slot_d;
         entry_ack_q    <= entry_ack_d;
         entry_reject_q <= entry_reject_d;
         exit_ack_q     <= exit_ack_d;
         exit_err_q     <= exit_err_d;
      end
   end
   always_comb begin
      bus.entry_ack    = entry_ack_q;
      bus.entry_slot   = entry_slot_q;
      bus.entry_reject = entry_reject_q;
      bus.exit_ack     = exit_ack_q;
      bus.exit_err     = exit_err_q;
      bus.gate_open    = state_q == OPEN;
      bus.occupied     = occ_q;
      bus.free_count   = cnt_q;
      bus.is_full      = full_q;
      bus.is_empty     = empty_q;
   end
endmodule

// File: tb/tb_parking_lot_ctrl.sv
// tb_parking_lot_ctrl: directed scenarios plus randomized traffic checked against a
// slot-array / last-event-time reference model.
module tb_parking_lot_ctrl;
   localparam int N = 8;
   localparam int G = 4;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   parking_lot_if #(.NUM_SLOTS(8)) bus8();
   parking_lot_if #(.NUM_SLOTS(6)) bus6();
   parking_lot_ctrl #(.NUM_SLOTS(8), .GATE_OPEN_CYCLES(G)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));
   parking_lot_ctrl #(.NUM_SLOTS(6), .GATE_OPEN_CYCLES(G)) dut6 (.clk(clk), .reset(reset), .bus(bus6.slave));
   int vectors = 0;
   int miscompares = 0;
   bit m_occ[N];
   int edge_n = 0;
   int last_ev = -100;
   bit e_ack, e_rej, x_ack, x_err, e_gate;
   int e_slot, e_free;
   function automatic logic [N-1:0] occ_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_occ[i];
      return v;
   endfunction
   // Drive one cycle of requests, take the edge, and advance the reference model.
   task automatic step(input bit rn, input bit er, input bit xr, input int xs);
      int low;
      bit ex_ok;
      reset = rn;
      bus8.entry_req = er;
      bus8.exit_req = xr;
      bus8.exit_slot = 3'(xs);
      low = -1;
      for (int i = 0; i < N; i++) if (!m_occ[i] && low < 0) low = i;
      ex_ok = xr && (xs < N) ? m_occ[xs % N] : 1'b0;
      @(posedge clk);
      edge_n++;
      if (!rn) begin
         {e_ack, e_rej, x_ack, x_err} = '0;
         for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
         last_ev = -100;
         e_slot = 0;
      end else begin
         e_ack = er && low >= 0;
         e_rej = er && low < 0;
         x_ack = ex_ok;
         x_err = xr && !ex_ok;
         if (e_ack) begin
            m_occ[low] = 1'b1;
            e_slot = low;
         end
         if (x_ack) m_occ[xs % N] = 1'b0;
         if (e_ack || x_ack) last_ev = edge_n;
      end
      e_free = 0;
      for (int i = 0; i < N; i++) e_free += m_occ[i] ? 0 : 1;
      e_gate = (edge_n - last_ev) < G;
      #1;
   endtask
   task automatic test_reset();
      step(0, 1, 1, 2);
      vectors++;
      if (bus8.entry_ack !== 1'b0 || bus8.exit_err !== 1'b0 || bus8.gate_open !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_pulses: ack=%b err=%b gate=%b, want 0 0 0", bus8.entry_ack, bus8.exit_err, bus8.gate_open);
      end
      repeat (3) step(1, 0, 0, 0);
      vectors++;
      if (bus8.occupied !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_occupied: got %h want 00", bus8.occupied);
      end
      vectors++;
      if (bus8.free_count !== 4'd8 || bus8.is_empty !== 1'b1 || bus8.is_full !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_count: free=%0d empty=%b full=%b want 8 1 0", bus8.free_count, bus8.is_empty, bus8.is_full);
      end
      vectors++;
      if ({bus8.entry_ack, bus8.entry_reject, bus8.exit_ack, bus8.exit_err, bus8.gate_open} !== 5'b0 || bus8.entry_slot !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_idle_outputs: pulses=%b slot=%0d want 00000 0",
                  {bus8.entry_ack, bus8.entry_reject, bus8.exit_ack, bus8.exit_err, bus8.gate_open}, bus8.entry_slot);
      end
   endtask
   task automatic test_fill();
      for (int k = 0; k < N; k++) begin
         step(1, 1, 0, 0);
         vectors++;
         if (bus8.entry_ack !== 1'b1 || int'(bus8.entry_slot) !== k) begin
            miscompares++;
            $display("FAIL fill_slot%0d: ack=%b slot=%0d want 1 %0d", k, bus8.entry_ack, bus8.entry_slot, k);
         end
      end
      vectors++;
      if (bus8.free_count !== 4'd0 || bus8.is_full !== 1'b1 || bus8.is_empty !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_full: free=%0d full=%b empty=%b want 0 1 0", bus8.free_count, bus8.is_full, bus8.is_empty);
      end
      step(1, 1, 0, 0);
      vectors++;
      if (bus8.entry_reject !== 1'b1 || bus8.entry_ack !== 1'b0 || bus8.occupied !== 8'hFF) begin
         miscompares++;
         $display("FAIL fill_reject: rej=%b ack=%b occ=%h want 1 0 ff", bus8.entry_reject, bus8.entry_ack, bus8.occupied);
      end
   endtask
   task automatic test_same_cycle();
      step(1, 1, 1, 3);
      vectors++;
      if (bus8.exit_ack !== 1'b1 || bus8.entry_reject !== 1'b1 || bus8.entry_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL same_cycle_pulses: xack=%b rej=%b ack=%b want 1 1 0", bus8.exit_ack, bus8.entry_reject, bus8.entry_ack);
      end
      vectors++;
      if (bus8.occupied !== 8'hF7 || bus8.free_count !== 4'd1 || bus8.is_full !== 1'b0) begin
         miscompares++;
         $display("FAIL same_cycle_state: occ=%h free=%0d full=%b want f7 1 0", bus8.occupied, bus8.free_count, bus8.is_full);
      end
      step(1, 1, 0, 0);
      vectors++;
      if (bus8.entry_ack !== 1'b1 || bus8.entry_slot !== 3'd3 || bus8.occupied !== 8'hFF) begin
         miscompares++;
         $display("FAIL same_cycle_realloc: ack=%b slot=%0d occ=%h want 1 3 ff", bus8.entry_ack, bus8.entry_slot, bus8.occupied);
      end
   endtask
   task automatic test_gate();
      int hi;
      step(0, 0, 0, 0);
      repeat (2) step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      hi = bus8.gate_open ? 1 : 0;
      for (int k = 0; k < 6; k++) begin
         step(1, 0, 0, 0);
         hi += bus8.gate_open ? 1 : 0;
      end
      vectors++;
      if (hi !== G) begin
         miscompares++;
         $display("FAIL gate_lone_width: open cycles=%0d want %0d", hi, G);
      end
      step(1, 1, 0, 0);
      repeat (2) step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      hi = 0;
      for (int k = 0; k < G - 1; k++) begin
         step(1, 0, 0, 0);
         hi += bus8.gate_open ? 1 : 0;
      end
      vectors++;
      if (hi !== G - 1) begin
         miscompares++;
         $display("FAIL gate_retrigger_hold: open cycles=%0d want %0d", hi, G - 1);
      end
      step(1, 0, 0, 0);
      vectors++;
      if (bus8.gate_open !== 1'b0) begin
         miscompares++;
         $display("FAIL gate_retrigger_close: gate=%b want 0", bus8.gate_open);
      end
   endtask
   task automatic test_exit_err();
      step(0, 0, 0, 0);
      repeat (5) step(1, 1, 0, 0);
      repeat (G + 1) step(1, 0, 0, 0);
      bus6.exit_req = 1'b1;
      bus6.exit_slot = 3'd7;
      step(1, 0, 1, 5);
      bus6.exit_req = 1'b0;
      vectors++;
      if (bus8.exit_err !== 1'b1 || bus8.exit_ack !== 1'b0 || bus8.occupied !== 8'h1F || bus8.gate_open !== 1'b0) begin
         miscompares++;
         $display("FAIL exit_unoccupied: err=%b xack=%b occ=%h gate=%b want 1 0 1f 0",
                  bus8.exit_err, bus8.exit_ack, bus8.occupied, bus8.gate_open);
      end
      vectors++;
      if (bus6.exit_err !== 1'b1 || bus6.exit_ack !== 1'b0 || bus6.occupied !== 6'h00 ||
          bus6.free_count !== 3'd6 || bus6.gate_open !== 1'b0) begin
         miscompares++;
         $display("FAIL exit_out_of_range: err=%b xack=%b occ=%h free=%0d gate=%b want 1 0 00 6 0",
                  bus6.exit_err, bus6.exit_ack, bus6.occupied, bus6.free_count, bus6.gate_open);
      end
      step(1, 0, 0, 0);
      vectors++;
      if (bus6.exit_err !== 1'b0 || bus8.exit_err !== 1'b0 || bus8.free_count !== 4'd3) begin
         miscompares++;
         $display("FAIL exit_err_pulse: err6=%b err8=%b free=%0d want 0 0 3", bus6.exit_err, bus8.exit_err, bus8.free_count);
      end
   endtask
   task automatic test_reset_mid();
      step(0, 0, 0, 0);
      repeat (3) step(1, 1, 0, 0);
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      vectors++;
      if (bus8.occupied !== 8'h00 || bus8.free_count !== 4'd8 || bus8.is_empty !== 1'b1 || bus8.gate_open !== 1'b0 ||
          bus8.entry_ack !== 1'b0 || bus8.entry_slot !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_mid: occ=%h free=%0d empty=%b gate=%b ack=%b slot=%0d want 00 8 1 0 0 0",
                  bus8.occupied, bus8.free_count, bus8.is_empty, bus8.gate_open, bus8.entry_ack, bus8.entry_slot);
      end
      step(1, 0, 0, 0);
      vectors++;
      if (bus8.gate_open !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_gate: gate=%b want 0", bus8.gate_open);
      end
   endtask
   task automatic test_random();
      logic [6:0] got, exp;
      step(0, 0, 0, 0);
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 59) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, $urandom_range(0, N - 1));
         got = {bus8.entry_ack, bus8.entry_reject, bus8.exit_ack, bus8.exit_err, bus8.gate_open, bus8.is_full, bus8.is_empty};
         exp = {e_ack, e_rej, x_ack, x_err, e_gate, e_free == 0, e_free == N};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL rand_flags[%0d]: got %b want %b", k, got, exp);
         end
         vectors++;
         if (bus8.occupied !== occ_vec() || int'(bus8.free_count) !== e_free) begin
            miscompares++;
            $display("FAIL rand_state[%0d]: occ=%h free=%0d want %h %0d", k, bus8.occupied, bus8.free_count, occ_vec(), e_free);
         end
         if (e_ack) begin
            vectors++;
            if (int'(bus8.entry_slot) !== e_slot) begin
               miscompares++;
               $display("FAIL rand_slot[%0d]: got %0d want %0d", k, bus8.entry_slot, e_slot);
            end
         end
      end
   endtask
   initial begin
      bus8.entry_req = 1'b0;
      bus8.exit_req = 1'b0;
      bus8.exit_slot = '0;
      bus6.entry_req = 1'b0;
      bus6.exit_req = 1'b0;
      bus6.exit_slot = '0;
      test_reset();
      test_fill();
      test_same_cycle();
      test_gate();
      test_exit_err();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
